team_06_pwm_audio_out: RTL
==========================

# team_06_pwm_audio_out

Downstream playback stage for the team_06 audio path. It accepts unsigned 8-bit samples (midscale 128) from the I2S/ADC receiver, one per single-cycle `sample_valid` strobe. Samples are buffered in a small FIFO and replayed as a fixed-frequency PWM waveform that drives the speaker filter. Underflow and overflow are flagged rather than corrupting the output.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥4.
- `REPEAT`, 4: PWM frames per sample; ≥1.

Ports:
- `clk` input 1: system clock (10 MHz); all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `sample_in` input 8: unsigned sample; sampled only when `sample_valid`=1.
- `sample_valid` input 1: single-cycle push strobe from the receiver's finished flag.
- `pwm_out` output 1: registered PWM output.
- `fifo_full` output 1: FIFO holds `DEPTH` entries.
- `fifo_empty` output 1: FIFO holds 0 entries.
- `overflow` output 1: 1-cycle pulse when a push is dropped.
- `underflow` output 1: 1-cycle pulse when a pop is attempted on an empty FIFO.
- `playing` output 1: 1 while in PLAY.

## Operation
- **PWM core**
  - 8-bit frame counter `cnt` runs 0..255 and wraps, so one frame is 256 clk.
  - `pwm_out` is registered as `cnt < duty`: duty 0 gives always-low; duty 255 gives 255/256 high.
  - Frame boundary: the cycle where `cnt`=255.
  - Repeat counter counts frame boundaries from 0 to `REPEAT`-1. A sample boundary is a frame boundary where the repeat count equals `REPEAT`-1.
- **FIFO**
  - Push on `sample_valid` if not full. If full, the sample is dropped and `overflow` pulses.
  - Push while full in the same cycle as a pop is accepted.
  - There is no bypass: a push into an empty FIFO is not visible to a pop in the same cycle.
- **FSM (two states)**
  - FILL: duty forced to 128. Transitions to PLAY at the next sample boundary once occupancy ≥ `DEPTH`/2.
  - PLAY: at each sample boundary:
    - If not empty: pop, and the popped value becomes duty.
    - If empty: `underflow` pulses, the FSM returns to FILL, and the duty fallback applies (see Configuration).
- Sample values are unsigned with no arithmetic on them; duty width is 8 bits.

## Timing
- Reset values:
  - `pwm_out`=0, `cnt`=0, repeat count=0.
  - duty=128, state=FILL, FIFO empty.
  - `fifo_empty`=1, `fifo_full`=0, `overflow`=0, `underflow`=0, `playing`=0.
- `fifo_full` and `fifo_empty` are registered and reflect occupancy after the cycle's push/pop.
- A new duty loads at the sample boundary and takes effect from `cnt`=0 of the following frame. `pwm_out` lags the compare by 1 clk.
- FILL→PLAY occurs at the sample boundary. The first pop happens at that same boundary, and `playing` rises the next cycle.
- Latency from the first push to the first sample on `pwm_out`: at least one sample boundary after occupancy reaches `DEPTH`/2.
- Reset mid-frame immediately clears all state; the FIFO contents are discarded.

## Configuration
- `TEAM_06_PWM_HOLD_ON_UNDERFLOW_EN`:
  - Defined: on underflow, duty keeps the last played sample, and FILL holds that duty instead of 128.
  - Undefined: on underflow and throughout FILL, duty is 128 (silence).
  - `underflow` pulse and FSM behaviour are identical either way.

## Structure
- Package `team_06_audio_pkg`:
  - `SAMPLE_W`=8, `PWM_W`=8, `MIDSCALE`=8'd128.
  - enum `pwm_state_t` {FILL, PLAY}.
- Sub-module `team_06_sample_fifo`:
  - Synchronous FIFO (params `WIDTH`, `DEPTH`).
  - push/pop, full/empty, occupancy count.
  - Drops on full push.
- Top: frame counter, repeat counter, FSM, duty register, pulse flags.

## Test plan
- Reset, no input → `pwm_out` duty 128/256 (high for `cnt` 0..127), `playing`=0, `fifo_empty`=1.
- Push 0x40, 0xC0, 0x00, 0xFF (`DEPTH`=8, `REPEAT`=4) → PLAY starts at the first sample boundary after the 4th push. The frames then show high counts of 64, 192, 0 and 255 per frame, each for 4 frames.
- Push 9 samples back-to-back with no pops → 9th dropped, `overflow` one pulse, `fifo_full`=1.
- In PLAY, stop pushes after 4 samples → `underflow` pulses at the 5th sample boundary and state returns to FILL. Duty becomes 128 (macro undefined) or stays 0xFF (macro defined, last sample 0xFF).
- Full FIFO with `sample_valid` on the sample-boundary cycle → pop and push both occur, no `overflow`, occupancy stays 8.
- Assert `rst` mid-frame in PLAY → next cycle `pwm_out`=0, `cnt`=0, `fifo_empty`=1, `playing`=0.

Source files
------------

// File: rtl/team_06_audio_pkg.sv
// rtl/team_06_audio_pkg.sv - shared widths, midscale constant and FSM state type for the PWM audio output
package team_06_audio_pkg;

  localparam int SAMPLE_W = 8;
  localparam int PWM_W    = 8;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 8'd128;

  typedef enum logic {
    FILL = 1'b0,
    PLAY = 1'b1
  } pwm_state_t;

endpackage

// File: rtl/team_06_sample_fifo.sv
// rtl/team_06_sample_fifo.sv - synchronous sample FIFO that drops pushes when full
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write strobe and data
//   pop, pop_data     read strobe; pop_data shows the oldest entry (show-ahead)
//   full, empty       registered flags, reflect occupancy after this cycle's push/pop
//   count             current occupancy
//   dropped           combinational: a push this cycle is being discarded
module team_06_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic [AW:0]      count_next;

  // A pop only sees entries already stored, so a push into an empty FIFO
  // cannot be popped in the same cycle. A push while full is still accepted
  // when a pop frees a slot in that cycle.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL_CNT) || pop_ok);
  assign dropped = push && !push_ok;

  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/team_06_pwm_audio_out.sv
// rtl/team_06_pwm_audio_out.sv - buffers 8-bit audio samples and replays them as fixed-rate PWM
//
// Optional feature macro: TEAM_06_PWM_HOLD_ON_UNDERFLOW_EN
//   defined   - on underflow and during FILL the last played duty is held
//   undefined - on underflow and during FILL the duty is midscale (silence)
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   sample_in       unsigned sample, captured when sample_valid=1
//   sample_valid    single-cycle push strobe
//   pwm_out         registered PWM output (cnt < duty, one clk behind the compare)
//   fifo_full       FIFO holds DEPTH entries
//   fifo_empty      FIFO holds no entries
//   overflow        1-cycle pulse when a push is dropped
//   underflow       1-cycle pulse when PLAY finds the FIFO empty at a sample boundary
//   playing         1 while in PLAY
module team_06_pwm_audio_out
  import team_06_audio_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int REPEAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                pwm_out,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                overflow,
  output logic                underflow,
  output logic                playing
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);
  localparam logic [AW:0]   HALF_CNT = (AW+1)'(DEPTH / 2);

  pwm_state_t          state;
  pwm_state_t          state_next;
  logic [PWM_W-1:0]    cnt;
  logic [RW-1:0]       rep;
  logic [PWM_W-1:0]    duty;
  logic [PWM_W-1:0]    duty_next;
  logic                frame_bnd;
  logic                sample_bnd;
  logic                pop;
  logic                underflow_next;
  logic                dropped;
  logic [SAMPLE_W-1:0] pop_data;
  logic [AW:0]         count;

  team_06_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sample_valid),
    .push_data (sample_in),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count),
    .dropped   (dropped)
  );

  assign frame_bnd  = (cnt == '1);
  assign sample_bnd = frame_bnd && (rep == REP_LAST);
  assign playing    = (state == PLAY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      rep <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (frame_bnd) begin
        rep <= (rep == REP_LAST) ? '0 : rep + 1'b1;
      end
    end
  end

  // The duty register only changes at a sample boundary (cnt=255), so the new
  // value governs the whole next frame starting at cnt=0.
  always_comb begin
    state_next     = state;
    duty_next      = duty;
    pop            = 1'b0;
    underflow_next = 1'b0;
    case (state)
      FILL: begin
`ifndef TEAM_06_PWM_HOLD_ON_UNDERFLOW_EN
        duty_next = MIDSCALE;
`endif
        if (sample_bnd && (count >= HALF_CNT)) begin
          state_next = PLAY;
          pop        = 1'b1;
          duty_next  = pop_data;
        end
      end
      PLAY: begin
        if (sample_bnd) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            duty_next = pop_data;
          end else begin
            underflow_next = 1'b1;
            state_next     = FILL;
`ifndef TEAM_06_PWM_HOLD_ON_UNDERFLOW_EN
            duty_next      = MIDSCALE;
`endif
          end
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      duty      <= MIDSCALE;
      pwm_out   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_next;
      duty      <= duty_next;
      pwm_out   <= (cnt < duty);
      overflow  <= dropped;
      underflow <= underflow_next;
    end
  end

endmodule
